// File: rtl/rgb_arb_pkg.sv
// Shared types and constants for the RGB LED arbiter and its PWM back end.
package rgb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        LINGER = 2'd2
    } arb_state_t;

    localparam int R_OFS  = 16;
    localparam int G_OFS  = 8;
    localparam int B_OFS  = 0;
    localparam int HOLD_W = 16;

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM generator; duty values are captured only at the period wrap
// so a running period is never shortened or stretched by a colour change.
module rgb_pwm
    import rgb_arb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        frame_tick
);

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_dutyR;
    logic [PWM_BITS-1:0] r_dutyG;
    logic [PWM_BITS-1:0] r_dutyB;
    logic                r_pwmR;
    logic                r_pwmG;
    logic                r_pwmB;
    logic                r_tick;
    logic                w_wrap;

    assign w_wrap = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dutyR <= '0;
            r_dutyG <= '0;
            r_dutyB <= '0;
            r_pwmR  <= 1'b0;
            r_pwmG  <= 1'b0;
            r_pwmB  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= w_wrap;
            // Only the top PWM_BITS of each 8-bit colour field set the duty
            if (w_wrap) begin
                r_dutyR <= rgb[R_OFS+7 -: PWM_BITS];
                r_dutyG <= rgb[G_OFS+7 -: PWM_BITS];
                r_dutyB <= rgb[B_OFS+7 -: PWM_BITS];
            end
            r_pwmR <= (r_cnt < r_dutyR);
            r_pwmG <= (r_cnt < r_dutyG);
            r_pwmB <= (r_cnt < r_dutyB);
        end
    end

    assign pwm_r      = r_pwmR;
    assign pwm_g      = r_pwmG;
    assign pwm_b      = r_pwmB;
    assign frame_tick = r_tick;

endmodule

// File: rtl/rgb_arbiter.sv
// Fixed-priority owner of the on-board RGB LED with a minimum-hold window
// against flicker; the owner's colour is turned into PWM by rgb_pwm.
module rgb_arbiter
    import rgb_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MIN_HOLD  = 1024,
    parameter int PWM_BITS  = 8,
    parameter int IDLE_TEST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [24*NUM_REQ-1:0]   req_rgb,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    busy,
    output logic                    frame_tick,
    output logic                    pwm_r,
    output logic                    pwm_g,
    output logic                    pwm_b,
    output logic                    test_mode
);

    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MIN_HOLD - 1);

    arb_state_t         r_state;
    arb_state_t         w_nextState;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_nextGnt;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   w_nextOwner;
    logic [23:0]        r_colour;
    logic [23:0]        w_nextColour;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_nextHold;
    logic               r_testMode;
    logic [OWN_W-1:0]   w_lowIdx;
    logic               w_anyReq;
    logic               w_ownerReq;
    logic               w_higherReq;
    logic               w_holdZero;
    logic               w_doGrant;
    logic               w_goIdle;

    assign w_anyReq    = |req;
    assign w_ownerReq  = req[r_owner];
    assign w_higherReq = w_anyReq && (w_lowIdx < r_owner);
    assign w_holdZero  = (r_hold == '0);

    // Lowest set index wins; scanning downward leaves the smallest index last
    always_comb begin
        w_lowIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lowIdx = OWN_W'(i);
            end
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextGnt    = r_gnt;
        w_nextOwner  = r_owner;
        w_nextColour = r_colour;
        w_nextHold   = w_holdZero ? '0 : r_hold - 1'b1;
        w_doGrant    = 1'b0;
        w_goIdle     = 1'b0;
        case (r_state)
            IDLE: begin
                w_doGrant = w_anyReq;
            end
            OWN: begin
                if (!w_ownerReq) begin
                    if (!w_holdZero) begin
                        w_nextState = LINGER;
                        w_nextGnt   = '0;
                    end else begin
                        w_doGrant = w_anyReq;
                        w_goIdle  = !w_anyReq;
                    end
                end else if (w_holdZero && w_higherReq) begin
                    w_doGrant = 1'b1;
                end else begin
                    w_nextColour = req_rgb[24*r_owner +: 24];
                end
            end
            LINGER: begin
                if (w_holdZero) begin
                    w_doGrant = w_anyReq;
                    w_goIdle  = !w_anyReq;
                end
            end
            default: begin
                w_goIdle = 1'b1;
            end
        endcase
        // A new grant switches owner directly, never passing through IDLE
        if (w_doGrant) begin
            w_nextState  = OWN;
            w_nextOwner  = w_lowIdx;
            w_nextGnt    = NUM_REQ'(1) << w_lowIdx;
            w_nextColour = req_rgb[24*w_lowIdx +: 24];
            w_nextHold   = HOLD_RELOAD;
        end else if (w_goIdle) begin
            w_nextState  = IDLE;
            w_nextGnt    = '0;
            w_nextColour = '0;
            w_nextHold   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_colour   <= '0;
            r_hold     <= '0;
            r_testMode <= (IDLE_TEST != 0);
        end else begin
            r_state    <= w_nextState;
            r_gnt      <= w_nextGnt;
            r_owner    <= w_nextOwner;
            r_colour   <= w_nextColour;
            r_hold     <= w_nextHold;
            r_testMode <= (IDLE_TEST != 0) && (w_nextState == IDLE);
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != IDLE);
    assign test_mode = r_testMode;

    rgb_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .rgb       (r_colour),
        .pwm_r     (pwm_r),
        .pwm_g     (pwm_g),
        .pwm_b     (pwm_b),
        .frame_tick(frame_tick)
    );

endmodule

// File: doc/rgb_arbiter.md
Name: rgb_arbiter

Overview:
- Shares the single on-board RGB LED between NUM_REQ requesters, for example the SPI command path, system status and the boot indicator.
- Uses fixed priority with a minimum-hold anti-flicker window.
- Converts the winning 24-bit colour into three on/off PWM streams that feed the in_r/in_g/in_b inputs of the LED driver wrapper.
- Also drives that wrapper's test_mode input when no requester owns the LED.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 has the highest priority.
- MIN_HOLD, 1024: minimum cycles a grant is held before preemption or release takes effect; range 1..65535.
- PWM_BITS, 8: PWM counter and duty width; colour fields are 8 bits, and only the top PWM_BITS of each are used.
- IDLE_TEST, 1: when 1, test_mode is asserted while in IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- req  in  NUM_REQ  per-requester request level
- req_rgb  in  24*NUM_REQ  per-requester colour; requester i occupies [24*i+23 : 24*i], ordered {R,G,B}
- gnt  out  NUM_REQ  one-hot grant, registered
- busy  out  1  LED is owned (state OWN or LINGER)
- frame_tick  out  1  one-cycle pulse when the PWM counter wraps
- pwm_r  out  1  red on/off, to in_r
- pwm_g  out  1  green on/off, to in_g
- pwm_b  out  1  blue on/off, to in_b
- test_mode  out  1  to the driver test_mode input

Behaviour:
- Clocking and reset:
  - One clock domain, clk; reset rst is synchronous and active-high.
  - On rst: state=IDLE, gnt=0, busy=0, hold_cnt=0, owner=0, latched colour=0, duty registers=0, PWM counter=0, frame_tick=0, pwm_*=0, test_mode=IDLE_TEST.
  - Reset mid-grant or mid-PWM-period takes effect on the next edge, with no completion of the current period.
- FSM states: IDLE, OWN, LINGER.
- IDLE:
  - If any req bit is set, grant the lowest set index i: owner<=i, gnt<=onehot(i), colour<=req_rgb[i], hold_cnt<=MIN_HOLD-1, next state OWN.
  - gnt is high on the cycle after req is first sampled high (1-cycle latency).
- OWN:
  - Colour tracks req_rgb[owner] every cycle (registered, 1-cycle latency).
  - hold_cnt decrements to 0 and saturates there.
  - Owner drops req with hold_cnt!=0: go to LINGER, gnt<=0, colour frozen at the last latched value.
  - Owner drops req with hold_cnt==0: re-arbitrate in the same cycle. Grant the lowest set req if any (reload hold_cnt, stay OWN); otherwise go to IDLE.
  - A higher-priority req (index < owner) with hold_cnt==0 preempts: grant switches directly to the new index, hold_cnt is reloaded, and there is no IDLE cycle.
  - Lower-priority requests never preempt.
- LINGER:
  - hold_cnt keeps decrementing; the frozen colour is displayed.
  - At hold_cnt==0, arbitrate as in IDLE: grant if any req, else go to IDLE.
  - Requests arriving during LINGER wait for hold_cnt==0, including a re-request by the former owner.
- Simultaneous events: on a release and a higher-priority request in the same cycle, the hold rule decides. With hold_cnt==0 the request wins immediately; otherwise go to LINGER.
- Output flags:
  - busy = (state != IDLE).
  - test_mode = IDLE_TEST & (state==IDLE), registered.
  - In IDLE the colour is 0, so pwm_* are 0.
- PWM:
  - Free-running PWM_BITS counter; period = 2^PWM_BITS cycles.
  - Duty registers load from the latched colour only when the counter wraps (max to 0), so a period is never cut short.
  - frame_tick is high in the cycle the counter reads 0.
  - pwm_x = (cnt < duty_x), registered.
  - Duty 0 gives constant 0; duty 255 gives 255 high cycles per 256.
- Width rules: hold_cnt is 16 bits, and MIN_HOLD=1 means preemption is possible on the cycle after grant. Priority encoding is combinational.

Decomposition:
- Package rgb_arb_pkg:
  - state enum (IDLE/OWN/LINGER)
  - colour field offsets R=16, G=8, B=0
  - HOLD_W=16
- Sub-module rgb_pwm:
  - inputs: clk, rst, rgb[23:0]
  - outputs: pwm_r, pwm_g, pwm_b, frame_tick
  - contains the counter, wrap-synchronised duty load and comparators.
- The arbiter FSM stays in rgb_arbiter.

Test Plan:
- Reset and grant: assert rst mid-grant with req=3'b010 → next cycle gnt=0, busy=0, pwm_*=0, test_mode=1. Then release rst → gnt=3'b010 one cycle after req is sampled, with test_mode=0.
- Priority and hold: MIN_HOLD=16, req1 granted with colour 24'hFF0000; raise req0 at cycle 5 → gnt stays 3'b010 until hold_cnt=0 (cycle 16 after grant), then switches to 3'b001 with no zero-grant cycle.
- Linger: req1 granted with colour 24'h00FF00 and MIN_HOLD=16; drop req1 at cycle 3 → state LINGER, gnt=0, busy=1, green PWM continues. At cycle 16 with no req → IDLE, busy=0.
- PWM duty: owner colour 24'h40_00_FF → per 256-cycle period pwm_r high exactly 64 cycles, pwm_g always 0, pwm_b high 255 cycles. Change the colour mid-period → new duty applies only after the next frame_tick.
- Simultaneous: with hold_cnt==0, drop req2 while raising req0 in the same cycle → gnt goes 3'b100 → 3'b001 directly. Repeat with hold_cnt!=0 → LINGER, then grant 3'b001 at hold expiry.
